// File: rtl/uwasic_onboarding_jasper.sv
// SPI-configured 16-output controller: each output is low, high,
// or driven by a shared 8-bit PWM (13-cycle prescale).
module uwasic_onboarding_jasper (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t state, state_next;

    logic [1:0] sclk_sync, copi_sync, ncs_sync;
    logic       sclk_prev, ncs_prev;
    logic       sclk_rise, ncs_rise, ncs_fall;

    logic [15:0] shift;
    logic [4:0]  bit_cnt;
    logic        commit;

    logic [15:0] en_out, en_pwm;
    logic [7:0]  duty;

    logic [3:0]  presc;
    logic [7:0]  pwm_cnt;
    logic        pwm;
    logic [15:0] out_next, out_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

    // nCS resets as if low so a frame already open across reset
    // never produces a falling edge; a real high must be seen first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            copi_sync <= 2'b00;
            ncs_sync  <= 2'b00;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], ui_in[0]};
            copi_sync <= {copi_sync[0], ui_in[1]};
            ncs_sync  <= {ncs_sync[0], ui_in[2]};
            sclk_prev <= sclk_sync[1];
            ncs_prev  <= ncs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign ncs_rise  = ncs_sync[1] & ~ncs_prev;
    assign ncs_fall  = ~ncs_sync[1] & ncs_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ncs_fall) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (ncs_rise) begin
                    state_next = IDLE;
                    commit     = (bit_cnt == 5'd16) && shift[15] &&
                                 (shift[14:8] <= 7'd4);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= 16'h0000;
            bit_cnt <= 5'd0;
        end else if (state == IDLE && ncs_fall) begin
            shift   <= 16'h0000;
            bit_cnt <= 5'd0;
        end else if (state == RECV && sclk_rise && !ncs_sync[1]) begin
            shift <= {shift[14:0], copi_sync[1]};
            // Saturate so very long frames can never wrap back to 16.
            if (bit_cnt != 5'd31) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out <= 16'h0000;
            en_pwm <= 16'h0000;
            duty   <= 8'h00;
        end else if (commit) begin
            case (shift[10:8])
                3'd0:    en_out[7:0]  <= shift[7:0];
                3'd1:    en_out[15:8] <= shift[7:0];
                3'd2:    en_pwm[7:0]  <= shift[7:0];
                3'd3:    en_pwm[15:8] <= shift[7:0];
                3'd4:    duty         <= shift[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= 4'd0;
            pwm_cnt <= 8'd0;
        end else if (presc == 4'd12) begin
            presc   <= 4'd0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            presc <= presc + 4'd1;
        end
    end

    assign pwm      = (duty == 8'hFF) | (pwm_cnt < duty);
    assign out_next = en_out & (~en_pwm | {16{pwm}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 16'h0000;
        end else begin
            out_q <= out_next;
        end
    end

    assign uo_out  = out_q[7:0];
    assign uio_out = out_q[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_jasper.sv
// Bench for uwasic_onboarding_jasper: directed frame table, PWM
// timing, and random frames against a frame-level register model.
module tb_uwasic_onboarding_jasper;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] mregs [5];

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic [7:0]  uo;
        logic [7:0]  uio;
    } vec_t;

    vec_t tbl [12];

    uwasic_onboarding_jasper dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_range(string name, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin();
        ui_in[0] = 1'b0;
        ui_in[2] = 1'b0;
        cyc(4);
    endtask

    task automatic spi_bits(logic [31:0] bits, int n);
        for (int i = n - 1; i >= 0; i--) begin
            ui_in[1] = bits[i];
            cyc(4);
            ui_in[0] = 1'b1;
            cyc(4);
            ui_in[0] = 1'b0;
        end
    endtask

    task automatic spi_end();
        cyc(4);
        ui_in[2] = 1'b1;
        cyc(4);
    endtask

    // Frame-level model: only a complete 16-bit write to 0..4 lands.
    task automatic model_apply(logic [31:0] bits, int n);
        if (n == 16 && bits[15] && bits[14:8] <= 7'd4) begin
            mregs[bits[10:8]] = bits[7:0];
        end
    endtask

    task automatic spi_frame(logic [31:0] bits, int n);
        spi_begin();
        spi_bits(bits, n);
        spi_end();
        model_apply(bits, n);
        cyc(10);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
    endtask

    task automatic model_expect(output logic [15:0] val,
                                output logic [15:0] care);
        logic [15:0] eo;
        logic [15:0] ep;
        eo = {mregs[1], mregs[0]};
        ep = {mregs[3], mregs[2]};
        val  = 16'h0000;
        care = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (!eo[i]) begin
                val[i] = 1'b0;
            end else if (!ep[i]) begin
                val[i] = 1'b1;
            end else if (mregs[4] == 8'hFF) begin
                val[i] = 1'b1;
            end else if (mregs[4] == 8'h00) begin
                val[i] = 1'b0;
            end else begin
                care[i] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [15:0] ev;
        logic [15:0] ec;
        logic [15:0] fr;
        logic [31:0] bits;
        logic [6:0]  addr;
        logic [7:0]  data;
        int n, hi, lo, bad, r;

        tbl[0]  = '{32'h000080F0, 16, 8'hF0, 8'h00};
        tbl[1]  = '{32'h000081CC, 16, 8'hF0, 8'hCC};
        tbl[2]  = '{32'h0000B0AA, 16, 8'hF0, 8'hCC};
        tbl[3]  = '{32'h00000055, 16, 8'hF0, 8'hCC};
        tbl[4]  = '{32'h00004008, 15, 8'hF0, 8'hCC};
        tbl[5]  = '{32'h00010023, 17, 8'hF0, 8'hCC};
        tbl[6]  = '{32'h0000800F, 16, 8'h0F, 8'hCC};
        tbl[7]  = '{32'h00008100, 16, 8'h0F, 8'h00};
        tbl[8]  = '{32'h000084FF, 16, 8'h0F, 8'h00};
        tbl[9]  = '{32'h00008203, 16, 8'h0F, 8'h00};
        tbl[10] = '{32'h00008400, 16, 8'h0C, 8'h00};
        tbl[11] = '{32'h00008201, 16, 8'h0E, 8'h00};

        ena    = 1'b1;
        uio_in = 8'h5A;
        ui_in  = 8'($urandom);
        rst    = 1'b1;
        model_reset();
        cyc(5);
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'hFF);

        ui_in = 8'b0000_0100;
        cyc(3);
        rst = 1'b0;
        cyc(30);
        check("idle_uo", uo_out, 8'h00);
        check("idle_uio", uio_out, 8'h00);
        check("idle_oe", uio_oe, 8'hFF);

        for (int i = 0; i < 12; i++) begin
            spi_frame(tbl[i].bits, tbl[i].n);
            check($sformatf("tbl%0d_uo", i), uo_out, tbl[i].uo);
            check($sformatf("tbl%0d_uio", i), uio_out, tbl[i].uio);
        end

        spi_frame(32'h8001, 16);
        spi_frame(32'h8480, 16);
        n = 0;
        while (uo_out[0] !== 1'b0 && n < 5000) begin cyc(1); n++; end
        n = 0;
        while (uo_out[0] !== 1'b1 && n < 5000) begin cyc(1); n++; end
        hi = 0;
        while (uo_out[0] === 1'b1 && hi < 5000) begin cyc(1); hi++; end
        lo = 0;
        while (uo_out[0] === 1'b0 && lo < 5000) begin cyc(1); lo++; end
        check_range("pwm50_high", hi, 1651, 1677);
        check_range("pwm50_period", hi + lo, 3327, 3329);
        check("pwm50_others", uo_out[7:1], 7'h00);

        spi_frame(32'h8400, 16);
        bad = 0;
        for (int i = 0; i < 6656; i++) begin
            cyc(1);
            if (uo_out[0] !== 1'b0) bad++;
        end
        check("duty00_const", bad, 0);

        spi_frame(32'h84FF, 16);
        bad = 0;
        for (int i = 0; i < 6656; i++) begin
            cyc(1);
            if (uo_out[0] !== 1'b1) bad++;
        end
        check("dutyFF_const", bad, 0);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            addr = (r <= 6) ? 7'(r % 5) : 7'($urandom_range(5, 127));
            data = 8'($urandom);
            if (addr == 7'd4) begin
                r = $urandom_range(0, 2);
                if (r == 0) data = 8'h00;
                if (r == 1) data = 8'hFF;
            end
            fr = {($urandom_range(0, 5) != 0), addr, data};
            r = $urandom_range(0, 4);
            n = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            if (n == 15) bits = {17'h0, fr[15:1]};
            else if (n == 17) bits = {15'h0, fr, 1'($urandom)};
            else bits = {16'h0, fr};
            spi_frame(bits, n);
            model_expect(ev, ec);
            check($sformatf("rnd%0d_uo", k), uo_out & ec[7:0],
                  ev[7:0] & ec[7:0]);
            check($sformatf("rnd%0d_uio", k), uio_out & ec[15:8],
                  ev[15:8] & ec[15:8]);
        end

        spi_frame(32'h80A5, 16);
        spi_frame(32'h8200, 16);
        check("pre_midrst_uo", uo_out, 8'hA5);
        spi_begin();
        spi_bits(32'h80, 8);
        rst = 1'b1;
        model_reset();
        cyc(3);
        check("midrst_uo", uo_out, 8'h00);
        check("midrst_uio", uio_out, 8'h00);
        rst = 1'b0;
        cyc(2);
        spi_bits(32'hFF, 8);
        spi_end();
        cyc(10);
        check("midrst_tail_uo", uo_out, 8'h00);
        check("midrst_tail_uio", uio_out, 8'h00);

        spi_frame(32'h805A, 16);
        check("recover_uo", uo_out, 8'h5A);
        check("recover_uio", uio_out, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
